// File: rtl/multicycle_accum_dp.sv
// multicycle_accum_dp: captures NOPS operands on start and folds them into an accumulator one per clock.
module multicycle_accum_dp #(
  parameter int WIDTH = 8,
  parameter int NOPS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [NOPS*WIDTH-1:0]   operands,
  output logic [WIDTH-1:0]        result,
  output logic                    done,
  output logic                    busy,
  output logic                    ovf,
  output logic                    zero
);
  localparam int IW = $clog2(NOPS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ops [NOPS];
  logic [WIDTH-1:0] acc, b, sum;
  logic [IW-1:0] idx;
  logic [1:0] mode_q;
  logic ovf_i, sub, step_ovf, last, go;
  always_comb begin
    b = ops[idx];
    sub = mode_q == 2'b01 ? 1'b0 : mode_q == 2'b10 ? idx[0] : 1'b1;
    sum = sub ? acc - b : acc + b;
    // operand signs differ on subtract (agree on add) and the result sign flips
    step_ovf = ((acc[WIDTH-1] ^ b[WIDTH-1]) == sub) && (sum[WIDTH-1] != acc[WIDTH-1]);
    last = idx == IW'(NOPS - 1);
    go = start && state != RUN;
    state_n = go ? RUN : state == RUN ? (last ? DONE : RUN) : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      for (int i = 0; i < NOPS; i++) ops[i] <= '0;
      acc <= '0;
      idx <= '0;
      mode_q <= '0;
      ovf_i <= 1'b0;
      result <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b1;
    end else begin
      state <= state_n;
      busy <= state_n == RUN;
      done <= state == RUN && last;
      if (go) begin
        for (int i = 0; i < NOPS; i++) ops[i] <= operands[i*WIDTH +: WIDTH];
        mode_q <= mode;
        acc <= operands[WIDTH-1:0];
        idx <= IW'(1);
        ovf_i <= 1'b0;
      end else if (state == RUN) begin
        acc <= sum;
        idx <= idx + IW'(1);
        ovf_i <= ovf_i | step_ovf;
        if (last) begin
          result <= sum;
          ovf <= ovf_i | step_ovf;
          zero <= sum == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_multicycle_accum_dp.sv
// tb_multicycle_accum_dp: directed checks of the accumulate datapath at 8x4 and 16x2.
module tb_multicycle_accum_dp;
  logic clk = 0, reset = 1, start = 0, start2 = 0;
  logic [1:0] mode = 0;
  logic [31:0] operands = 0, operands2 = 0;
  logic [7:0] result;
  logic [15:0] result2;
  logic done, busy, ovf, zero, done2, busy2, ovf2, zero2;
  int checks = 0, errors = 0, lat, bc, nd;

  multicycle_accum_dp dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .operands(operands),
    .result(result), .done(done), .busy(busy), .ovf(ovf), .zero(zero)
  );
  multicycle_accum_dp #(.WIDTH(16), .NOPS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .mode(2'b00), .operands(operands2),
    .result(result2), .done(done2), .busy(busy2), .ovf(ovf2), .zero(zero2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  // start at the current negedge, poke start/operands once mid-run if asked, wait for done
  task automatic run(input logic [1:0] m, input logic [31:0] o, input bit poke, output int l, output int n);
    mode = m;
    operands = o;
    start = 1;
    @(negedge clk);
    start = 0;
    l = 0;
    n = 0;
    while (!done && l < 10) begin
      n += int'(busy);
      l++;
      if (poke) begin
        start = l == 1;
        operands = 32'hFFFF_FFFF;
        mode = 2'b01;
      end
      @(negedge clk);
    end
    start = 0;
  endtask

  initial begin
    #1 reset = 0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 1);
    check("rst_zero2", zero2, 1);
    reset = 1;
    @(negedge clk);

    run(2'b00, pk(100, 20, 30, 5), 0, lat, bc);
    check("sub_lat", lat, 3);
    check("sub_busy_cycles", bc, 3);
    check("sub_result", result, 45);
    check("sub_ovf", ovf, 0);
    check("sub_zero", zero, 0);
    check("sub_busy_low", busy, 0);
    @(negedge clk);
    check("sub_done_fall", done, 0);

    run(2'b01, pk(100, 50, 0, 0), 0, lat, bc);
    check("add_result", result, 8'h96);
    check("add_ovf", ovf, 1);
    @(negedge clk);
    check("add_hold", result, 8'h96);
    run(2'b01, pk(1, 2, 3, 4), 0, lat, bc);
    check("add2_result", result, 10);
    check("add2_ovf_cleared", ovf, 0);

    run(2'b10, pk(10, 3, 7, 20), 0, lat, bc);
    check("alt_result", result, 8'hFA);
    check("alt_ovf", ovf, 0);
    run(2'b11, pk(10, 3, 7, 20), 0, lat, bc);
    check("m11_result", result, 8'hEC);
    run(2'b00, pk(10, 3, 7, 20), 0, lat, bc);
    check("m00_result", result, 8'hEC);

    @(negedge clk);
    run(2'b00, pk(5, 2, 2, 1), 1, lat, bc);
    check("poke_lat", lat, 3);
    check("poke_result", result, 0);
    check("poke_zero", zero, 1);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      nd += int'(done);
    end
    check("poke_extra_done", nd, 0);
    check("poke_hold", result, 0);

    run(2'b00, pk(100, 20, 30, 5), 0, lat, bc);
    check("b2b_first", result, 45);
    run(2'b01, pk(1, 1, 1, 1), 0, lat, bc);
    check("b2b_lat", lat, 3);
    check("b2b_busy_cycles", bc, 3);
    check("b2b_result", result, 4);
    check("b2b_ovf", ovf, 0);

    @(negedge clk);
    mode = 2'b00;
    operands = pk(100, 20, 30, 5);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #2 reset = 0;
    #1;
    check("arst_result", result, 0);
    check("arst_zero", zero, 1);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ovf", ovf, 0);
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      nd += int'(done);
    end
    check("arst_no_done", nd, 0);
    reset = 1;
    @(negedge clk);
    run(2'b00, pk(100, 20, 30, 5), 0, lat, bc);
    check("post_rst_lat", lat, 3);
    check("post_rst_result", result, 45);

    operands2 = {16'd1, 16'd1000};
    start2 = 1;
    @(negedge clk);
    start2 = 0;
    check("w16_busy", busy2, 1);
    check("w16_done_early", done2, 0);
    @(negedge clk);
    check("w16_done", done2, 1);
    check("w16_result", result2, 999);
    check("w16_zero", zero2, 0);
    check("w16_ovf", ovf2, 0);
    @(negedge clk);
    check("w16_done_fall", done2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
